iob_ptfloat_unpack: RTL and testbench

IOB_PTFLOAT_UNPACK -- requirements
Module: iob_ptfloat_unpack

---
 rtl/iob_ptfloat_unpack_pkg.sv | 26 ++
 rtl/iob_ptfloat_defs.sv | 15 +
 rtl/iob_ptfloat_field_split.sv | 46 ++++
 rtl/iob_reg.sv | 30 +++
 rtl/iob_ptfloat_unpack.sv | 125 ++++++++++++
 tb/tb_iob_ptfloat_unpack.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/iob_ptfloat_unpack_pkg.sv
// Types and constants shared by the ptfloat unpack stage.
// Latency: none (package).
// Backpressure: not applicable.
`ifndef IOB_PTFLOAT_DEFS_VH
`include "iob_ptfloat_defs.sv"
`endif
package iob_ptfloat_unpack_pkg;
    localparam int PTF_EXP_W = `EXP_MAX_W + 2;
    localparam int PTF_MAN_W = `MAN_MAX_W;
    localparam logic [PTF_EXP_W-1:0] PTF_EXP_MAX = PTF_EXP_W'(`EXP_MAX);
    localparam logic [PTF_EXP_W-1:0] PTF_EXP_MIN = PTF_EXP_W'(`EXP_MIN);

    // Decoded word as it travels down the pipeline.
    typedef struct packed {
        logic [PTF_EXP_W-1:0] exp;
        logic [PTF_MAN_W-1:0] man;
        logic                 zero;
        logic                 sat;
    } ptf_dec_t;

    // A mantissa whose sign bit equals the next bit carries no leading
    // significant bit, i.e. it is not normalized.
    function automatic logic is_unnormalized(input logic [PTF_MAN_W-1:0] man);
        return man[PTF_MAN_W-1] == man[PTF_MAN_W-2];
    endfunction
endpackage

// File: rtl/iob_ptfloat_defs.sv
// Shared ptfloat format defines (iob_ptfloat_defs header), used by every ptfloat stage.
// Latency: none (definitions only).
// Backpressure: not applicable.
//
// Values fit the default 32-bit word with a 4-bit exponent-width field:
//   - the field is 28 bits wide;
//   - the exponent field is at most 15 bits wide (ew = 4'hF).
`ifndef IOB_PTFLOAT_DEFS_VH
`define IOB_PTFLOAT_DEFS_VH
`define EXP_MAX_W 15
`define MAN_MAX_W 28
`define F_MAX_W 28
`define EXP_MAX 16383
`define EXP_MIN (-16383)
`endif

// File: rtl/iob_ptfloat_field_split.sv
// Combinational ptfloat field split: word -> ew, sign-extended exponent E, mantissa fraction.
// Latency: 0 (combinational).
// Backpressure: not applicable.
//
// Word layout: {field[F_W-1:0], ew[EW_W-1:0]}.
// The top ew bits of field hold the signed exponent E; the remaining bits are
// the fraction, which is returned left-aligned.
module iob_ptfloat_field_split #(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4,
    parameter int E_W    = 17
) (
    input  logic [DATA_W-1:0]      data_i,
    output logic [EW_W-1:0]        ew_o,
    output logic [E_W-1:0]         e_sext_o,
    output logic [DATA_W-EW_W-1:0] frac_o,
    output logic                   field_zero_o
);
    localparam int F_W  = DATA_W - EW_W;
    localparam int SH_W = $clog2(F_W + 1);
    localparam logic [SH_W-1:0] F_W_SH = SH_W'(F_W);

    logic [F_W-1:0]        field;
    logic [EW_W-1:0]       ew;
    logic [SH_W-1:0]       shamt;
    logic signed [F_W-1:0] e_shift;

    assign ew    = data_i[EW_W-1:0];
    assign field = data_i[DATA_W-1:EW_W];
    assign shamt = F_W_SH - SH_W'(ew);

    // An arithmetic right shift brings the top ew bits of field down, already
    // sign-extended. With ew = 0 the exponent field is empty, so the
    // exponent is 0.
    always_comb begin
        e_shift = '0;
        if (ew != '0) begin
            e_shift = $signed(field) >>> shamt;
        end
    end

    assign ew_o         = ew;
    assign e_sext_o     = E_W'(e_shift);
    assign frac_o       = field << ew;
    assign field_zero_o = (field == '0);
endmodule

// File: rtl/iob_reg.sv
// Generic register with async active-high reset, clock enable and load enable.
// Latency: 1 enabled cycle.
// Backpressure: none; holds its value while cke_i or en_i is low.
//
// Ports:
//   - clk_i, arst_i, cke_i: clock, asynchronous reset, clock enable.
//   - en_i: load enable.
//   - data_i / data_o: next value / registered value.
module iob_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= '0;
        end else if (cke_i && en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/iob_ptfloat_unpack.sv
// ptfloat unpack: packed {field, ew} word -> signed exponent, signed mantissa, zero/sat flags.
// Latency: 2 cke-enabled cycles from start_i to done_o.
// Backpressure: none; one word per enabled cycle, cke_i low freezes the whole pipe.
//
// Ports:
//   - clk_i, arst_i (async active-high), cke_i.
//   - start_i / data_i: word in.
//   - done_o: result valid.
//   - exp_o, man_o, zero_o, sat_o: decoded result; each holds its value between words.
//
// Build option PTFLOAT_SUBNORMALS_EN: when defined, a word with ew all ones,
// E == 0 and an unnormalized mantissa decodes with exponent `EXP_MIN.
`ifndef IOB_PTFLOAT_DEFS_VH
`include "iob_ptfloat_defs.sv"
`endif
module iob_ptfloat_unpack
    import iob_ptfloat_unpack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   cke_i,
    input  logic                   start_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   done_o,
    output logic [`EXP_MAX_W+1:0]  exp_o,
    output logic [`MAN_MAX_W-1:0]  man_o,
    output logic                   zero_o,
    output logic                   sat_o
);
    localparam int F_W = DATA_W - EW_W;

    logic [EW_W-1:0]      ew;
    logic [PTF_EXP_W-1:0] e_sext;
    logic [F_W-1:0]       frac;
    logic                 field_zero;
    logic                 ew_ones;
    logic [PTF_EXP_W-1:0] exp_c;
    logic [PTF_MAN_W-1:0] man_c;

    ptf_dec_t dec_d;
    ptf_dec_t dec_s1_q;
    ptf_dec_t dec_q;
    logic     vld_s1_q;
    logic     done_q;

    iob_ptfloat_field_split #(
        .DATA_W(DATA_W),
        .EW_W  (EW_W),
        .E_W   (PTF_EXP_W)
    ) u_field_split (
        .data_i      (data_i),
        .ew_o        (ew),
        .e_sext_o    (e_sext),
        .frac_o      (frac),
        .field_zero_o(field_zero)
    );

    assign ew_ones = &ew;

    always_comb begin
        man_c = PTF_MAN_W'(frac);
        exp_c = e_sext;
        // The encoder stores negative exponents minus one; undo that here.
        if (e_sext[PTF_EXP_W-1]) begin
            exp_c = e_sext + PTF_EXP_W'(1);
        end
`ifdef PTFLOAT_SUBNORMALS_EN
        if (ew_ones && (e_sext == '0) && is_unnormalized(man_c)) begin
            exp_c = PTF_EXP_MIN;
        end
`endif
        dec_d.zero = field_zero;
        dec_d.exp  = field_zero ? '0 : exp_c;
        dec_d.man  = field_zero ? '0 : man_c;
        // Saturation code: widest exponent field holding the largest exponent.
        dec_d.sat  = ew_ones && (exp_c == PTF_EXP_MAX);
    end

    // Stage 1 loads every enabled cycle; only the valid bit qualifies it.
    iob_reg #(.DATA_W($bits(ptf_dec_t))) u_s1_dec (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .en_i  (1'b1),
        .data_i(dec_d),
        .data_o(dec_s1_q)
    );

    iob_reg #(.DATA_W(1)) u_s1_vld (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .en_i  (1'b1),
        .data_i(start_i),
        .data_o(vld_s1_q)
    );

    // Output stage only loads valid words, so results persist between words.
    iob_reg #(.DATA_W($bits(ptf_dec_t))) u_out_dec (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .en_i  (vld_s1_q),
        .data_i(dec_s1_q),
        .data_o(dec_q)
    );

    iob_reg #(.DATA_W(1)) u_out_vld (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .cke_i (cke_i),
        .en_i  (1'b1),
        .data_i(vld_s1_q),
        .data_o(done_q)
    );

    assign done_o = done_q;
    assign exp_o  = dec_q.exp;
    assign man_o  = dec_q.man;
    assign zero_o = dec_q.zero;
    assign sat_o  = dec_q.sat;
endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Testbench for iob_ptfloat_unpack (DATA_W=32, EW_W=4).
// Stimulus: a vector table, hand-written stall/reset sequences and random encoded words.
// Expected results are queued at drive time and compared when done_o fires.
module tb_iob_ptfloat_unpack;
    typedef struct packed {
        logic [16:0] e;
        logic [27:0] m;
        logic        z;
        logic        s;
    } res_t;

    typedef struct packed {
        logic [31:0] data;
        res_t        res;
    } vec_t;

    localparam int NV = 11;

    logic        clk_i  = 1'b0;
    logic        arst_i = 1'b0;
    logic        cke_i;
    logic        start_i;
    logic [31:0] data_i;
    logic        done_o;
    logic [16:0] exp_o;
    logic [27:0] man_o;
    logic        zero_o;
    logic        sat_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic cke_seen = 1'b0;
    res_t sb[$];
    int   done_cycs[$];
    vec_t vecs[NV];

    iob_ptfloat_unpack #(.DATA_W(32), .EW_W(4)) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .start_i(start_i),
        .data_i (data_i),
        .done_o (done_o),
        .exp_o  (exp_o),
        .man_o  (man_o),
        .zero_o (zero_o),
        .sat_o  (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input int e, input logic [27:0] m,
                                input logic z, input logic s);
        vec_t v;
        v.data  = d;
        v.res.e = 17'(e);
        v.res.m = m;
        v.res.z = z;
        v.res.s = s;
        return v;
    endfunction

    // cke_seen is the enable used at the last edge: a held done_o during a
    // stall is not a new result.
    always @(posedge clk_i) begin
        cyc      <= cyc + 1;
        cke_seen <= cke_i;
    end

    always @(negedge clk_i) begin
        res_t r;
        if (!arst_i && done_o && cke_seen) begin
            done_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d, required no pending word", cyc);
            end else begin
                r = sb.pop_front();
                check("result", {exp_o, man_o, zero_o, sat_o}, r);
            end
        end
    end

    task automatic drive(input logic st, input logic ck, input logic [31:0] d, input res_t r,
                         output int c);
        @(posedge clk_i);
        #1;
        start_i = st;
        cke_i   = ck;
        data_i  = d;
        c       = cyc;
        if (st && ck) sb.push_back(r);
    endtask

    task automatic idle(input int n);
        int c;
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, $urandom, '0, c);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1);
        idle(1);
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Encoder-side model: choose ew, exponent field and fraction, build the word.
    task automatic rand_word(output logic [31:0] d, output res_t r);
        int          ew;
        int          e;
        logic [27:0] mask;
        logic [27:0] lo;
        logic [27:0] field;
        logic [27:0] man;
        logic [16:0] ex;
        logic        z;
        ew = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) begin
            ew = 15;
            e  = 16383;
        end else if (ew == 0) begin
            e = 0;
        end else begin
            e = $urandom_range(0, (1 << ew) - 1);
            if (e >= (1 << (ew - 1))) e -= (1 << ew);
        end
        mask = (28'd1 << (28 - ew)) - 28'd1;
        lo   = 28'($urandom) & mask;
        if ($urandom_range(0, 9) == 0) lo = '0;
        field = (28'(e) << (28 - ew)) | lo;
        man   = lo << ew;
        ex    = 17'((e < 0) ? e + 1 : e);
`ifdef PTFLOAT_SUBNORMALS_EN
        if (ew == 15 && e == 0 && field != '0 && man[27] == man[26]) ex = 17'(-16383);
`endif
        z = (field == '0);
        if (z) begin
            ex  = '0;
            man = '0;
        end
        d   = {field, 4'(ew)};
        r.e = ex;
        r.m = man;
        r.z = z;
        r.s = (ew == 15) && (ex == 17'd16383);
    endtask

    initial begin
        int          c;
        int          c0;
        logic [31:0] d;
        res_t        r;

        vecs[0]  = mk(32'h0, 0, 28'h0, 1'b1, 1'b0);
        vecs[1]  = mk({28'h4000000, 4'd0}, 0, 28'h4000000, 1'b0, 1'b0);
        vecs[2]  = mk({3'b010, 25'h0800000, 4'd3}, 2, 28'h4000000, 1'b0, 1'b0);
        vecs[3]  = mk({3'b110, 25'h0800000, 4'd3}, -1, 28'h4000000, 1'b0, 1'b0);
        vecs[4]  = mk({15'h3FFF, 13'h1000, 4'hF}, 16383, 28'h8000000, 1'b0, 1'b1);
        vecs[5]  = mk({15'h3FFE, 13'h0800, 4'hF}, 16382, 28'h4000000, 1'b0, 1'b0);
        vecs[6]  = mk({28'h0, 4'd5}, 0, 28'h0, 1'b1, 1'b0);
        vecs[7]  = mk({15'h4000, 13'h0000, 4'hF}, -16383, 28'h0, 1'b0, 1'b0);
`ifdef PTFLOAT_SUBNORMALS_EN
        vecs[8]  = mk({15'h0000, 13'h0400, 4'hF}, -16383, 28'h2000000, 1'b0, 1'b0);
`else
        vecs[8]  = mk({15'h0000, 13'h0400, 4'hF}, 0, 28'h2000000, 1'b0, 1'b0);
`endif
        vecs[9]  = mk({1'b1, 27'h0000001, 4'd1}, 0, 28'h0000002, 1'b0, 1'b0);
        vecs[10] = mk({4'h7, 24'hABCDEF, 4'd4}, 7, 28'hABCDEF0, 1'b0, 1'b0);

        cke_i   = 1'b0;
        start_i = 1'b0;
        data_i  = '0;
        #2 arst_i = 1'b1;
        #2;
        check("reset_state", {done_o, exp_o, man_o, zero_o, sat_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        cke_i  = 1'b1;

        // Vector table, back to back.
        done_cycs.delete();
        c0 = 0;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, 1'b1, vecs[i].data, vecs[i].res, c);
            if (i == 0) c0 = c;
        end
        drain();
        check("table_done_count", 64'(done_cycs.size()), 64'(NV));
        check("first_latency", 64'((done_cycs.size() > 0) ? done_cycs[0] - c0 : -1), 64'd2);

        // Outputs hold while no word is valid.
        idle(3);
        check("hold_between_words", {exp_o, man_o, zero_o, sat_o}, vecs[NV-1].res);

        // Four words with a one-cycle clock-enable stall after the first.
        done_cycs.delete();
        drive(1'b1, 1'b1, vecs[2].data, vecs[2].res, c0);
        drive(1'b1, 1'b0, vecs[4].data, vecs[4].res, c);
        drive(1'b1, 1'b1, vecs[4].data, vecs[4].res, c);
        drive(1'b1, 1'b1, vecs[7].data, vecs[7].res, c);
        drive(1'b1, 1'b1, vecs[10].data, vecs[10].res, c);
        drain();
        check("stall_done_count", 64'(done_cycs.size()), 64'd4);
        check("stall_first_done", 64'((done_cycs.size() > 0) ? done_cycs[0] - c0 : -1), 64'd3);
        check("stall_last_done", 64'((done_cycs.size() > 3) ? done_cycs[3] - c0 : -1), 64'd6);

        // Reset with words in flight: outputs clear at once, those words never complete.
        drive(1'b1, 1'b1, vecs[3].data, vecs[3].res, c);
        drive(1'b1, 1'b1, vecs[5].data, vecs[5].res, c);
        #2;
        arst_i = 1'b1;
        sb.delete();
        #1;
        check("reset_immediate", {done_o, exp_o, man_o, zero_o, sat_o}, 64'd0);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        arst_i  = 1'b0;
        done_cycs.delete();
        idle(5);
        check("no_done_after_reset", 64'(done_cycs.size()), 64'd0);

        // First word after reset release.
        drive(1'b1, 1'b1, vecs[9].data, vecs[9].res, c0);
        drain();
        check("latency_after_reset", 64'((done_cycs.size() > 0) ? done_cycs[0] - c0 : -1), 64'd2);

        // Random encoded words with random clock-enable stalls.
        done_cycs.delete();
        for (int i = 0; i < 80; i++) begin
            rand_word(d, r);
            drive(($urandom_range(0, 5) != 0), ($urandom_range(0, 3) != 0), d, r, c);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
